// File: rtl/mem_branch_resolve.sv
// mem_branch_resolve: inst1 MEM-stage branch resolution, mispredict redirect and 2-bit BHT.
// Optional macro BRU_STATS_EN adds saturating branch/mispredict statistics counters.
module mem_branch_resolve #(
   parameter int         PC_W     = 8,
   parameter int         IDX_W    = 4,
   parameter logic [1:0] CNT_INIT = 2'b01,
   parameter int         STAT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_branch_mem,
   input  logic              i_bit26_mem,
   input  logic [31:0]       i_rs_data_mem,
   input  logic [31:0]       i_rt_data_mem,
   input  logic [PC_W-1:0]   i_pc_mem,
   input  logic [PC_W-1:0]   i_pc_branch_mem,
   input  logic              i_prediction_mem,
   input  logic [PC_W-1:0]   i_pc_fetch,
   output logic              o_predict_taken_f,
   output logic              o_mispredict,
   output logic [PC_W-1:0]   o_redirect_pc,
   output logic [STAT_W-1:0] o_branch_count,
   output logic [STAT_W-1:0] o_mispredict_count
);
   logic [1:0]       r_bht [(1<<IDX_W)];
   logic             w_taken, w_upd, w_mispredict;
   logic [IDX_W-1:0] w_uidx, w_fidx;
   logic [1:0]       w_cur, w_nxt, w_look;
   logic             w_unused;
   always_comb begin
      w_taken      = (i_rs_data_mem == i_rt_data_mem) ^ i_bit26_mem;
      w_upd        = i_branch_mem & ~i_reset;
      w_mispredict = w_upd & (w_taken != i_prediction_mem);
      w_uidx       = i_pc_mem[IDX_W-1:0];
      w_fidx       = i_pc_fetch[IDX_W-1:0];
      w_cur        = r_bht[w_uidx];
      w_nxt        = w_taken ? (&w_cur ? w_cur : w_cur + 2'd1) : (|w_cur ? w_cur - 2'd1 : w_cur);
      // same-index update is forwarded so fetch sees the trained counter this cycle
      w_look       = (w_upd && w_uidx == w_fidx) ? w_nxt : r_bht[w_fidx];
   end
   assign w_unused          = ^i_pc_fetch[PC_W-1:IDX_W];
   assign o_mispredict      = w_mispredict;
   assign o_redirect_pc     = (w_mispredict & w_taken) ? i_pc_branch_mem : i_pc_mem + PC_W'(1);
   assign o_predict_taken_f = ~i_reset & w_look[1];
   always_ff @(posedge i_clk) begin
      if (i_reset)
         for (int k = 0; k < (1<<IDX_W); k++) r_bht[k] <= CNT_INIT;
      else if (w_upd)
         r_bht[w_uidx] <= w_nxt;
   end
`ifdef BRU_STATS_EN
   logic [STAT_W-1:0] r_branch_count, r_mispredict_count;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (i_branch_mem && !(&r_branch_count)) r_branch_count <= r_branch_count + STAT_W'(1);
         if (w_mispredict && !(&r_mispredict_count)) r_mispredict_count <= r_mispredict_count + STAT_W'(1);
      end
   end
   assign o_branch_count     = r_branch_count;
   assign o_mispredict_count = r_mispredict_count;
`else
   assign o_branch_count     = '0;
   assign o_mispredict_count = '0;
`endif
endmodule

// File: tb/tb_mem_branch_resolve.sv
// tb_mem_branch_resolve: directed plus random checks of mem_branch_resolve against a counter-table model.
module tb_mem_branch_resolve;
   logic        clk = 0, reset = 1, branch_mem = 0, bit26_mem = 0, prediction_mem = 0;
   logic [31:0] rs_data_mem = 0, rt_data_mem = 0;
   logic [7:0]  pc_mem = 0, pc_branch_mem = 0, pc_fetch = 0;
   logic        predict_taken_f, mispredict;
   logic [7:0]  redirect_pc;
   logic [15:0] branch_count, mispredict_count;
   int          checks = 0, errors = 0;
   int          bht [16];
   int          m_bc = 0, m_mc = 0;

   mem_branch_resolve dut (
      .i_clk(clk), .i_reset(reset), .i_branch_mem(branch_mem), .i_bit26_mem(bit26_mem),
      .i_rs_data_mem(rs_data_mem), .i_rt_data_mem(rt_data_mem), .i_pc_mem(pc_mem),
      .i_pc_branch_mem(pc_branch_mem), .i_prediction_mem(prediction_mem), .i_pc_fetch(pc_fetch),
      .o_predict_taken_f(predict_taken_f), .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
      .o_branch_count(branch_count), .o_mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic br, input logic b26, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [7:0] pc, input logic [7:0] tgt,
                        input logic pred, input logic [7:0] pf);
      logic tk, mp, ep;
      logic [7:0] erd;
      int ui, fi, nx, ebc, emc;
      reset = rst; branch_mem = br; bit26_mem = b26; rs_data_mem = rs; rt_data_mem = rt;
      pc_mem = pc; pc_branch_mem = tgt; prediction_mem = pred; pc_fetch = pf;
      tk  = (rs == rt) != b26;
      mp  = !rst && br && (tk != pred);
      erd = (mp && tk) ? tgt : pc + 8'd1;
      ui  = pc % 16;
      fi  = pf % 16;
      nx  = tk ? ((bht[ui] + 1 > 3) ? 3 : bht[ui] + 1) : ((bht[ui] - 1 < 0) ? 0 : bht[ui] - 1);
      ep  = !rst && (((br && ui == fi) ? nx : bht[fi]) >= 2);
`ifdef BRU_STATS_EN
      ebc = m_bc; emc = m_mc;
`else
      ebc = 0; emc = 0;
`endif
      @(negedge clk);
      check("mispredict", {31'd0, mispredict}, {31'd0, mp});
      check("redirect_pc", {24'd0, redirect_pc}, {24'd0, erd});
      check("predict_taken_f", {31'd0, predict_taken_f}, {31'd0, ep});
      check("branch_count", {16'd0, branch_count}, ebc);
      check("mispredict_count", {16'd0, mispredict_count}, emc);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) bht[i] = 1;
         m_bc = 0; m_mc = 0;
      end else if (br) begin
         bht[ui] = nx;
         if (m_bc < 65535) m_bc++;
         if (mp && m_mc < 65535) m_mc++;
      end
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      drive(1, 1, 0, 5, 5, 8'h01, 8'h40, 0, 8'h01);
      for (int i = 0; i < 16; i++) drive(0, 0, 0, 3, 3, 8'h10, 8'h00, 0, 8'(i));
      drive(0, 1, 0, 32'h5, 32'h5, 8'h03, 8'h20, 0, 8'h03);
      drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h03);
      drive(0, 1, 1, 32'hA, 32'hA, 8'hFF, 8'h30, 1, 8'h00);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 7, 7, 8'h07, 8'h50, 1, 8'h07);
      drive(0, 1, 0, 7, 8, 8'h07, 8'h50, 1, 8'h07);
      drive(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h07);
      drive(0, 1, 0, 9, 9, 8'h05, 8'h60, 0, 8'h15);
      drive(1, 1, 0, 9, 9, 8'h05, 8'h60, 0, 8'h05);
      drive(0, 1, 0, 9, 9, 8'h05, 8'h60, 0, 8'h05);
      drive(0, 1, 0, 9, 1, 8'h05, 8'h60, 1, 8'h05);
      drive(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      drive(0, 1, 0, 2, 2, 8'h11, 8'h22, 1, 8'h00);
      drive(0, 1, 0, 2, 3, 8'h12, 8'h22, 1, 8'h00);
      drive(0, 1, 1, 2, 3, 8'h13, 8'h22, 0, 8'h00);
      drive(0, 1, 1, 4, 4, 8'h14, 8'h22, 1, 8'h00);
      drive(0, 0, 0, 6, 6, 8'h15, 8'h22, 0, 8'h00);
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, b;
         logic [7:0]  p;
         a = $urandom;
         b = $urandom_range(0, 1) ? a : $urandom;
         p = 8'($urandom);
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom), a, b, p,
               8'($urandom), 1'($urandom), $urandom_range(0, 1) ? p : 8'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
